// File: rtl/cam_pwr_pkg.sv
// Shared definitions for the camera power sequencer: state encoding, default
// timing values and the per-state pin levels.
package cam_pwr_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_LOCK = 3'd1,
      PWDN_HOLD = 3'd2,
      RST_HOLD  = 3'd3,
      SETTLE    = 3'd4,
      INIT      = 3'd5,
      RUN       = 3'd6
   } cam_state_e;

   localparam int T_LOCK_DEF   = 16;
   localparam int T_PWDN_DEF   = 1000;
   localparam int T_RST_DEF    = 1000;
   localparam int T_SETTLE_DEF = 20000;
   localparam int CNT_W_DEF    = 16;

   typedef struct packed {
      logic pwdn;
      logic reset_n;
      logic xclk_en;
   } cam_pins_t;

   // WAIT_LOCK shares the IDLE levels so a lock loss parks the camera safely.
   function automatic cam_pins_t pins_for(input cam_state_e st);
      cam_pins_t p;
      case (st)
         PWDN_HOLD: p = '{pwdn: 1'b1, reset_n: 1'b0, xclk_en: 1'b1};
         RST_HOLD:  p = '{pwdn: 1'b0, reset_n: 1'b0, xclk_en: 1'b1};
         SETTLE:    p = '{pwdn: 1'b0, reset_n: 1'b1, xclk_en: 1'b1};
         INIT:      p = '{pwdn: 1'b0, reset_n: 1'b1, xclk_en: 1'b1};
         RUN:       p = '{pwdn: 1'b0, reset_n: 1'b1, xclk_en: 1'b1};
         default:   p = '{pwdn: 1'b1, reset_n: 1'b0, xclk_en: 1'b0};
      endcase
      return p;
   endfunction

endpackage

// File: rtl/lock_filt.sv
// Consecutive-lock filter: locked rises on the T_LOCK_CYC-th consecutive
// cycle with lock_n low since the last clear.
module lock_filt
   import cam_pwr_pkg::*;
#(
   parameter int T_LOCK_CYC = T_LOCK_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic lock_n,
   output logic locked
);

   logic [CNT_W-1:0] cnt_r;
   logic             full_s;

   assign full_s = (cnt_r == CNT_W'(T_LOCK_CYC - 1));
   assign locked = full_s & ~lock_n;

   // Streak counter, saturating one short of the target so locked stays combinational.
   always_ff @(posedge clk) begin
      if (reset || clr || lock_n) begin
         cnt_r <= CNT_W'(0);
      end else if (!full_s) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/cam_pwr_seq.sv
// Camera power-up sequencer: waits for PLL lock, then walks power-down,
// reset and settle phases before requesting register initialisation.
module cam_pwr_seq
   import cam_pwr_pkg::*;
#(
   parameter int T_LOCK_CYC   = T_LOCK_DEF,
   parameter int T_PWDN_CYC   = T_PWDN_DEF,
   parameter int T_RST_CYC    = T_RST_DEF,
   parameter int T_SETTLE_CYC = T_SETTLE_DEF,
   parameter int CNT_W        = CNT_W_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pll_lock_n,
   input  logic       enable,
   input  logic       init_done,
   output logic       cam_pwdn,
   output logic       cam_reset_n,
   output logic       cam_xclk_en,
   output logic       init_req,
   output logic       ready,
   output logic       lock_err,
   output logic [2:0] state
);

   cam_state_e       state_r, state_nx_s;
   logic [CNT_W-1:0] timer_r, timer_nx_s;
   logic             lock_err_r, lock_err_nx_s;
   logic             locked_s, filt_clr_s, in_seq_s, timed_s, timer_hit_s;
   cam_pins_t        pins_nx_s;
   logic             cam_pwdn_r, cam_reset_n_r, cam_xclk_en_r, init_req_r, ready_r;

   assign filt_clr_s = (state_r != WAIT_LOCK);
   assign in_seq_s   = (state_r inside {PWDN_HOLD, RST_HOLD, SETTLE, INIT, RUN});

   lock_filt #(
      .T_LOCK_CYC (T_LOCK_CYC),
      .CNT_W      (CNT_W)
   ) u_lock_filt (
      .clk    (clk),
      .reset  (reset),
      .clr    (filt_clr_s),
      .lock_n (pll_lock_n),
      .locked (locked_s)
   );

   // Terminal-count decode for the timed states.
   always_comb begin
      timed_s     = 1'b1;
      timer_hit_s = 1'b0;
      case (state_r)
         PWDN_HOLD: timer_hit_s = (timer_r == CNT_W'(T_PWDN_CYC - 1));
         RST_HOLD:  timer_hit_s = (timer_r == CNT_W'(T_RST_CYC - 1));
         SETTLE:    timer_hit_s = (timer_r == CNT_W'(T_SETTLE_CYC - 1));
         default:   timed_s     = 1'b0;
      endcase
   end

   // Next-state logic; disable outranks lock loss, which outranks normal progress.
   always_comb begin
      state_nx_s    = state_r;
      lock_err_nx_s = lock_err_r;
      if (!enable) begin
         state_nx_s    = IDLE;
         lock_err_nx_s = 1'b0;
      end else if (in_seq_s && pll_lock_n) begin
         state_nx_s    = WAIT_LOCK;
         lock_err_nx_s = 1'b1;
      end else begin
         case (state_r)
            IDLE:      state_nx_s = WAIT_LOCK;
            WAIT_LOCK: state_nx_s = locked_s    ? PWDN_HOLD : WAIT_LOCK;
            PWDN_HOLD: state_nx_s = timer_hit_s ? RST_HOLD  : PWDN_HOLD;
            RST_HOLD:  state_nx_s = timer_hit_s ? SETTLE    : RST_HOLD;
            SETTLE:    state_nx_s = timer_hit_s ? INIT      : SETTLE;
            INIT:      state_nx_s = init_done   ? RUN       : INIT;
            RUN:       state_nx_s = RUN;
            default:   state_nx_s = IDLE;
         endcase
      end
   end

   // Timer restarts on every state change and only runs in timed states.
   always_comb begin
      if (state_nx_s != state_r) begin
         timer_nx_s = CNT_W'(0);
      end else if (timed_s) begin
         timer_nx_s = timer_r + CNT_W'(1);
      end else begin
         timer_nx_s = CNT_W'(0);
      end
      pins_nx_s = pins_for(state_nx_s);
   end

   // State, timer and output registers; outputs follow the next state so they align with state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= IDLE;
         timer_r       <= CNT_W'(0);
         lock_err_r    <= 1'b0;
         cam_pwdn_r    <= 1'b1;
         cam_reset_n_r <= 1'b0;
         cam_xclk_en_r <= 1'b0;
         init_req_r    <= 1'b0;
         ready_r       <= 1'b0;
      end else begin
         state_r       <= state_nx_s;
         timer_r       <= timer_nx_s;
         lock_err_r    <= lock_err_nx_s;
         cam_pwdn_r    <= pins_nx_s.pwdn;
         cam_reset_n_r <= pins_nx_s.reset_n;
         cam_xclk_en_r <= pins_nx_s.xclk_en;
         init_req_r    <= (state_nx_s == INIT) && (state_r != INIT);
         ready_r       <= (state_nx_s == RUN);
      end
   end

   assign cam_pwdn    = cam_pwdn_r;
   assign cam_reset_n = cam_reset_n_r;
   assign cam_xclk_en = cam_xclk_en_r;
   assign init_req    = init_req_r;
   assign ready       = ready_r;
   assign lock_err    = lock_err_r;
   assign state       = state_r;

endmodule

// File: tb/tb_cam_pwr_seq.sv
// Bench for cam_pwr_seq: directed scenarios with literal expectations plus a
// randomized run, all outputs compared every cycle against a phase-level model.
module tb_cam_pwr_seq;

   localparam int TL = 4;
   localparam int TP = 8;
   localparam int TR = 8;
   localparam int TS = 16;

   logic       clk = 1'b0;
   logic       reset, pll_lock_n, enable, init_done;
   logic       cam_pwdn, cam_reset_n, cam_xclk_en, init_req, ready, lock_err;
   logic [2:0] state;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit sim_end  = 1'b0;

   // Model: phase 0..6 (idle, wait, pwdn, rst, settle, init, run)
   int m_ph     = 0;
   int m_age    = 0;
   int m_streak = 0;
   bit m_err    = 1'b0;
   bit m_ireq   = 1'b0;
   bit m_valid  = 1'b0;
   int dur [7]  = '{0, 0, TP, TR, TS, 0, 0};

   always #5 clk = ~clk;

   cam_pwr_seq #(
      .T_LOCK_CYC   (TL),
      .T_PWDN_CYC   (TP),
      .T_RST_CYC    (TR),
      .T_SETTLE_CYC (TS),
      .CNT_W        (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pll_lock_n  (pll_lock_n),
      .enable      (enable),
      .init_done   (init_done),
      .cam_pwdn    (cam_pwdn),
      .cam_reset_n (cam_reset_n),
      .cam_xclk_en (cam_xclk_en),
      .init_req    (init_req),
      .ready       (ready),
      .lock_err    (lock_err),
      .state       (state)
   );

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   // Advance the model by one clock using the inputs the next edge will sample.
   task automatic model_step(input logic rst, input logic en, input logic lk_n, input logic dn);
      int prev;
      if (rst) begin
         m_ph = 0; m_age = 0; m_streak = 0; m_err = 1'b0; m_ireq = 1'b0; m_valid = 1'b1;
      end else if (m_valid) begin
         prev = m_ph;
         if (!en) begin
            m_ph = 0; m_err = 1'b0;
         end else if (m_ph >= 2 && lk_n) begin
            m_ph = 1; m_err = 1'b1;
         end else if (m_ph == 0) begin
            m_ph = 1;
         end else if (m_ph == 1) begin
            m_streak = lk_n ? 0 : m_streak + 1;
            if (m_streak >= TL) m_ph = 2;
         end else if (m_ph <= 4) begin
            m_age++;
            if (m_age == dur[m_ph]) m_ph++;
         end else if (m_ph == 5 && dn) begin
            m_ph = 6;
         end
         if (m_ph != prev) begin
            m_age = 0; m_streak = 0;
         end
         m_ireq = (m_ph == 5) && (prev != 5);
      end
   endtask

   // Per-cycle compare against the model on the falling edge.
   initial begin
      while (!sim_end) begin
         @(negedge clk);
         if (m_valid && !sim_end) begin
            chk("state",       state,       8'(m_ph));
            chk("cam_pwdn",    cam_pwdn,    8'(m_ph <= 2));
            chk("cam_reset_n", cam_reset_n, 8'(m_ph >= 4));
            chk("cam_xclk_en", cam_xclk_en, 8'(m_ph >= 2));
            chk("init_req",    init_req,    8'(m_ireq));
            chk("ready",       ready,       8'(m_ph == 6));
            chk("lock_err",    lock_err,    8'(m_err));
         end
         model_step(reset, enable, pll_lock_n, init_done);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog cycle=%0d", cyc);
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic go(input int c);
      while (cyc < c) tick();
   endtask

   // Two reset cycles, then cycle 0 with enable high and lock held.
   task automatic start_seq();
      reset = 1'b1; enable = 1'b0; pll_lock_n = 1'b0; init_done = 1'b0;
      tick();
      tick();
      reset = 1'b0; enable = 1'b1; cyc = 0;
   endtask

   initial begin
      // Nominal sequence
      start_seq();
      chk("n_idle0", state, 8'd0);
      go(1);  chk("n_wait1", state, 8'd1); chk("n_model1", 8'(m_ph), 8'd1);
      go(4);  chk("n_wait4", state, 8'd1);
      go(5);  chk("n_pwdn5", state, 8'd2); chk("n_xclk5", cam_xclk_en, 8'd1);
      go(12); chk("n_pwdn12", state, 8'd2);
      go(13); chk("n_rst13", state, 8'd3); chk("n_pwdn13", cam_pwdn, 8'd0);
      go(20); chk("n_rst20", state, 8'd3);
      go(21); chk("n_settle21", state, 8'd4); chk("n_rstn21", cam_reset_n, 8'd1);
      go(36); chk("n_settle36", state, 8'd4); chk("n_ireq36", init_req, 8'd0);
      go(37); chk("n_init37", state, 8'd5); chk("n_ireq37", init_req, 8'd1);
      chk("n_model37", 8'(m_ph), 8'd5);
      go(38); chk("n_ireq38", init_req, 8'd0);
      go(40); chk("n_rdy40", ready, 8'd0); init_done = 1'b1;
      go(41); init_done = 1'b0; chk("n_rdy41", ready, 8'd1); chk("n_run41", state, 8'd6);

      // Lock glitch in WAIT_LOCK
      start_seq();
      go(3);  pll_lock_n = 1'b1;
      go(4);  pll_lock_n = 1'b0;
      go(7);  chk("g_wait7", state, 8'd1);
      go(8);  chk("g_pwdn8", state, 8'd2);

      // Lock loss in SETTLE
      start_seq();
      go(25); pll_lock_n = 1'b1;
      go(26); pll_lock_n = 1'b0;
      chk("l_err26", lock_err, 8'd1); chk("l_state26", state, 8'd1);
      chk("l_pwdn26", cam_pwdn, 8'd1); chk("l_rstn26", cam_reset_n, 8'd0);
      chk("l_xclk26", cam_xclk_en, 8'd0);
      go(30); chk("l_pwdn30", state, 8'd2); chk("l_sticky30", lock_err, 8'd1);

      // Simultaneous disable and lock loss in RUN
      start_seq();
      go(40); init_done = 1'b1;
      go(41); init_done = 1'b0;
      go(45); enable = 1'b0; pll_lock_n = 1'b1;
      go(46); pll_lock_n = 1'b0;
      chk("s_state46", state, 8'd0); chk("s_err46", lock_err, 8'd0); chk("s_rdy46", ready, 8'd0);

      // Reset during RST_HOLD
      start_seq();
      go(15); reset = 1'b1;
      go(16); reset = 1'b0;
      chk("r_state16", state, 8'd0); chk("r_pwdn16", cam_pwdn, 8'd1);
      chk("r_rstn16", cam_reset_n, 8'd0); chk("r_xclk16", cam_xclk_en, 8'd0);
      go(17); chk("r_wait17", state, 8'd1);
      go(21); chk("r_pwdn21", state, 8'd2);

      // Stray init_done in SETTLE
      start_seq();
      go(30); init_done = 1'b1;
      go(31); init_done = 1'b0; chk("d_state31", state, 8'd4); chk("d_rdy31", ready, 8'd0);
      go(37); chk("d_init37", state, 8'd5); chk("d_ireq37", init_req, 8'd1);
      go(40); chk("d_init40", state, 8'd5);
      go(42); init_done = 1'b1;
      go(43); init_done = 1'b0; chk("d_run43", state, 8'd6); chk("d_rdy43", ready, 8'd1);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         reset      = ($urandom_range(0, 299) == 0);
         enable     = ($urandom_range(0, 149) != 0);
         pll_lock_n = (i < 2000) ? ($urandom_range(0, 99) < 1) : ($urandom_range(0, 19) == 0);
         init_done  = ($urandom_range(0, 7) == 0);
         tick();
      end
      reset = 1'b0; enable = 1'b1; pll_lock_n = 1'b0; init_done = 1'b0;
      tick();
      tick();
      sim_end = 1'b1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
